// File: rtl/d_strobe_pkg.sv
// Shared types and defaults for the registered strobe decoder.
package d_strobe_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned DEF_AW  = 4;
    localparam int unsigned DEF_HW  = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/d_dec_onehot.sv
// Combinational AW-to-2^AW active-low one-hot decoder with enable.
module d_dec_onehot
    import d_strobe_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic [AW-1:0]        sel,
    input  logic                 en,
    output logic [(1<<AW)-1:0]   z
);

    always_comb begin
        z = '1;
        if (en) begin
            z[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/d_strobe_dec.sv
// Registered address decoder driving one timed active-low strobe per request.
module d_strobe_dec
    import d_strobe_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned HW = DEF_HW
) (
    input  logic                 sys_clk,
    input  logic                 resetl,
    input  logic [AW-1:0]        a,
    input  logic                 g1n,
    input  logic                 g2n,
    input  logic                 req,
    input  logic [HW-1:0]        hold,
    output logic [(1<<AW)-1:0]   z,
    output logic                 busy,
    output logic                 done,
    output logic                 abort
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
    logic          gg;

    assign gg = ~(g1n | g2n);

    // State register
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic; the recovery edge doubles as the first acceptance
    // edge so back-to-back strobes are separated by exactly one high cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        unique case (state_q)
            IDLE, RECOVER: begin
                abort_d = 1'b0;
                if (state_q == RECOVER) begin
                    state_d = IDLE;
                end
                if (req && gg) begin
                    addr_d  = a;
                    cnt_d   = hold;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (!gg) begin
                    state_d = RECOVER;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                abort_d = 1'b0;
            end
        endcase
    end

    d_dec_onehot #(
        .AW (AW)
    ) u_dec (
        .sel (addr_q),
        .en  (state_q == STROBE),
        .z   (z)
    );

    // Status decoded from registered state only
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == RECOVER);
    assign abort = (state_q == RECOVER) & abort_q;

endmodule
